transformcoder_pipe: RTL
========================

# transformcoder_pipe

Pipelined, parametrised successor to the 4x4 transform/quantiser stage: accepts one 4x4 residual block per valid/ready handshake and emits quantised coefficients three cycles later. Supports H.264 core 4x4 forward transform and luma DC Hadamard mode, with intra/inter rounding and per-block QP. It also emits a non-zero coefficient count. It sits between residual generation and the entropy coder, and stalls cleanly under back-pressure.

## Interface
- BIT_LENGTH, 15: residual and coefficient elements are signed [BIT_LENGTH:0].
- IW, BIT_LENGTH+8: internal signed width of the transform datapath.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; 0 clears all state.
- in_valid  input  1  block present on residuals/qp/mode/intra.
- in_ready  output  1  block accepted when in_valid & in_ready.
- residuals  input  [BIT_LENGTH:0] x16  raster order, index 4*row+col, signed.
- qp  input  6  quantiser parameter; values above 51 are clamped to 51.
- mode  input  1  0 = core 4x4 transform, 1 = DC Hadamard.
- intra  input  1  1 = intra rounding, 0 = inter rounding.
- out_valid  output  1  processedres/nzc valid.
- out_ready  input  1  downstream accepts when out_valid & out_ready.
- processedres  output  [BIT_LENGTH:0] x16  quantised coefficients, raster order, signed.
- nzc  output  5  count of non-zero processedres, 0..16.

## Operation
- Three stages: S1 row pass, S2 column pass, S3 quantise. Each stage holds a valid bit and carries its own latched qp/mode/intra.
- Capture: qp, mode and intra are sampled only on the handshake. Later changes to those inputs do not affect an in-flight block.
- Core mode:
  - Cf rows are [1,1,1,1], [2,1,-1,-2], [1,-1,-1,1], [1,-2,2,-1].
  - W = Cf·X·Cfᵀ.
  - Position class a = (even, even), b = (odd, odd), c = otherwise.
- DC mode:
  - H rows are [1,1,1,1], [1,1,-1,-1], [1,-1,-1,1], [1,-1,1,-1].
  - Y = H·X·H, then W = sign(Y)·(|Y|>>1).
  - All positions use class a.
- Quantise:
  - qbits = 15 + qp/6.
  - f = 2^qbits/3 (intra) or 2^qbits/6 (inter), floor.
  - Core: Z = sign(W)·((|W|·MF + f) >> qbits).
  - DC: Z = sign(W)·((|W|·MF + 2f) >> (qbits+1)).
- MF table, qp%6 → (a, b, c):
  - 0 → 13107, 5243, 8066
  - 1 → 11916, 4660, 7490
  - 2 → 10082, 4194, 6554
  - 3 → 9362, 3647, 5825
  - 4 → 8192, 3355, 5243
  - 5 → 7282, 2893, 4559
- Widths: transform passes run in IW bits with no overflow for any input. Products must be at least IW+14 bits.
- Saturation: Z is saturated to [-(2^BIT_LENGTH), 2^BIT_LENGTH-1] before output. nzc counts the saturated values.

## Timing
- Latency: exactly 3 cycles from an accepting edge to out_valid, with no back-pressure.
- Throughput: one block per cycle.
- Stall: advance = !out_valid | out_ready, and in_ready = advance (combinational).
  - When advance = 0, every stage register holds.
- Handshake rules:
  - processedres and nzc are stable while out_valid & !out_ready.
  - Blocks leave in acceptance order; none are dropped or duplicated.
- Bubbles: a stage with valid 0 propagates a bubble. Data in invalid stages is don't-care; all datapath registers still reset to 0.
- Reset (reset = 0, any time, including mid-stall):
  - Immediately clears all stage valid bits.
  - processedres = 0, nzc = 0, out_valid = 0.
  - in_ready reads 1 after reset because out_valid = 0.
- Simultaneous events: on the same edge, an accept and an output consume both advance; full-rate streaming holds with out_ready = 1.

## Test plan
- Zeros: all-zero block, any qp, both modes → all processedres = 0, nzc = 0, out_valid exactly 3 cycles after accept.
- DC term: all residuals = 1, qp = 0, intra, core → processedres[0] = 6, others 0, nzc = 1. The same block with all residuals = -1 → processedres[0] = -6.
- Single impulse: residuals[0] = 100, others 0, qp = 0, intra, core → [0] = 40, [1] = 49, [5] = 64, nzc = 16.
- DC Hadamard: all residuals = 1, qp = 0, intra, mode = 1 → processedres[0] = 1, others 0, nzc = 1.
- Saturation: BIT_LENGTH = 15, all residuals = 32767, qp = 0, core → processedres[0] = 32767.
- Back-pressure and reset:
  - Hold out_ready = 0 and offer 4 consecutive blocks with distinct qp → first 3 accepted, in_ready = 0 on the 4th, outputs held stable.
  - Release out_ready → blocks emerge in order with correct per-block qp.
  - Assert reset mid-stall → out_valid = 0 and all outputs 0 immediately.

Source files
------------

// File: rtl/transformcoder_pipe_if.sv
// Block-level handshake bundle for the 4x4 transform/quantiser pipeline.
// The master side is whoever produces residual blocks and consumes coefficients.
// The slave side is transformcoder_pipe itself.
interface transformcoder_pipe_if #(
   parameter int BIT_LENGTH = 15
);
   logic                       in_valid;
   logic                       in_ready;
   logic [15:0][BIT_LENGTH:0]  residuals;
   logic [5:0]                 qp;
   logic                       mode;
   logic                       intra;
   logic                       out_valid;
   logic                       out_ready;
   logic [15:0][BIT_LENGTH:0]  processedres;
   logic [4:0]                 nzc;

   modport master (
      output in_valid, residuals, qp, mode, intra, out_ready,
      input  in_ready, out_valid, processedres, nzc
   );

   modport slave (
      input  in_valid, residuals, qp, mode, intra, out_ready,
      output in_ready, out_valid, processedres, nzc
   );
endinterface

// File: rtl/transformcoder_pipe.sv
// Three-stage 4x4 forward transform and quantiser.
// S1 applies the row butterfly, S2 the column butterfly, S3 quantises,
// saturates and counts non-zero coefficients. Core mode uses the H.264
// integer transform; DC mode uses the 4x4 Hadamard with a halving step.
// The whole pipe freezes when the output is held by the consumer.
module transformcoder_pipe #(
   parameter int BIT_LENGTH = 15,
   parameter int IW         = BIT_LENGTH + 8
) (
   input logic                  clk,
   input logic                  reset,
   transformcoder_pipe_if.slave bus
);

   localparam int CW = BIT_LENGTH + 1;
   localparam int PW = IW + 16;

   typedef enum logic [1:0] {
      CLS_A,
      CLS_B,
      CLS_C
   } pos_class_t;

   // Sign-extend one residual element into the transform width.
   function automatic logic signed [IW-1:0] sx(input logic [BIT_LENGTH:0] v);
      return IW'($signed(v));
   endfunction

   // Shared 4-point butterfly; core and Hadamard differ only in the odd outputs.
   function automatic logic [3:0][IW-1:0] butterfly(
      input logic signed [IW-1:0] x0,
      input logic signed [IW-1:0] x1,
      input logic signed [IW-1:0] x2,
      input logic signed [IW-1:0] x3,
      input logic                 dc
   );
      logic signed [IW-1:0] s03;
      logic signed [IW-1:0] d03;
      logic signed [IW-1:0] s12;
      logic signed [IW-1:0] d12;
      logic [3:0][IW-1:0]   y;
      s03  = x0 + x3;
      d03  = x0 - x3;
      s12  = x1 + x2;
      d12  = x1 - x2;
      y[0] = s03 + s12;
      y[2] = s03 - s12;
      if (dc) begin
         y[1] = d03 + d12;
         y[3] = d03 - d12;
      end else begin
         y[1] = (d03 <<< 1) + d12;
         y[3] = d03 - (d12 <<< 1);
      end
      return y;
   endfunction

   // Multiplication factor by qp%6 and coefficient position class.
   function automatic logic [13:0] mf_lookup(input logic [2:0] qmod, input pos_class_t cls);
      logic [13:0] ma;
      logic [13:0] mb;
      logic [13:0] mc;
      case (qmod)
         3'd0:    begin ma = 14'd13107; mb = 14'd5243; mc = 14'd8066; end
         3'd1:    begin ma = 14'd11916; mb = 14'd4660; mc = 14'd7490; end
         3'd2:    begin ma = 14'd10082; mb = 14'd4194; mc = 14'd6554; end
         3'd3:    begin ma = 14'd9362;  mb = 14'd3647; mc = 14'd5825; end
         3'd4:    begin ma = 14'd8192;  mb = 14'd3355; mc = 14'd5243; end
         default: begin ma = 14'd7282;  mb = 14'd2893; mc = 14'd4559; end
      endcase
      case (cls)
         CLS_A:   return ma;
         CLS_B:   return mb;
         default: return mc;
      endcase
   endfunction

   // Sign-magnitude quantisation of one coefficient with output saturation.
   // In DC mode the Hadamard result is halved before scaling.
   function automatic logic [CW-1:0] quantise(
      input logic signed [IW-1:0] w,
      input logic [13:0]          mf,
      input logic [PW-1:0]        rnd,
      input logic [4:0]           sh,
      input logic                 dc
   );
      logic [IW-1:0] absw;
      logic [PW-1:0] mag;
      absw = w[IW-1] ? IW'(-w) : IW'(w);
      if (dc) begin
         absw = absw >> 1;
      end
      mag = ((PW'(absw) * PW'(mf)) + rnd) >> sh;
      if (w[IW-1]) begin
         if (mag >= PW'(2 ** BIT_LENGTH)) begin
            return {1'b1, {BIT_LENGTH{1'b0}}};
         end
         return CW'(-mag);
      end
      if (mag >= PW'(2 ** BIT_LENGTH - 1)) begin
         return {1'b0, {BIT_LENGTH{1'b1}}};
      end
      return CW'(mag);
   endfunction

   logic                 advance;
   logic                 accept;
   logic [5:0]           qp_clamped;

   logic                 s1_valid;
   logic [15:0][IW-1:0]  s1_data;
   logic [5:0]           s1_qp;
   logic                 s1_mode;
   logic                 s1_intra;

   logic                 s2_valid;
   logic [15:0][IW-1:0]  s2_data;
   logic [5:0]           s2_qp;
   logic                 s2_mode;
   logic                 s2_intra;

   logic                 out_valid_q;
   logic [15:0][CW-1:0]  out_data_q;
   logic [4:0]           nzc_q;

   logic [15:0][IW-1:0]  row_next;
   logic [15:0][IW-1:0]  col_next;
   logic [15:0][CW-1:0]  q_next;
   logic [4:0]           nzc_next;

   logic [3:0]           qdiv;
   logic [2:0]           qmod;
   logic [4:0]           qbits;
   logic [PW-1:0]        fbase;
   logic [PW-1:0]        rnd;
   logic [4:0]           sh;

   assign advance      = !out_valid_q | bus.out_ready;
   assign accept       = bus.in_valid & advance;
   assign bus.in_ready = advance;
   assign qp_clamped   = (bus.qp > 6'd51) ? 6'd51 : bus.qp;

   assign bus.out_valid    = out_valid_q;
   assign bus.processedres = out_data_q;
   assign bus.nzc          = nzc_q;

   // Row pass straight off the input bus, one butterfly per row.
   for (genvar r = 0; r < 4; r++) begin : g_row
      logic [3:0][IW-1:0] ry;
      assign ry = butterfly(sx(bus.residuals[4*r+0]), sx(bus.residuals[4*r+1]),
                            sx(bus.residuals[4*r+2]), sx(bus.residuals[4*r+3]),
                            bus.mode);
      assign row_next[4*r+0] = ry[0];
      assign row_next[4*r+1] = ry[1];
      assign row_next[4*r+2] = ry[2];
      assign row_next[4*r+3] = ry[3];
   end

   // Column pass over the S1 row results, one butterfly per column.
   for (genvar k = 0; k < 4; k++) begin : g_col
      logic [3:0][IW-1:0] cy;
      assign cy = butterfly($signed(s1_data[k]), $signed(s1_data[4+k]),
                            $signed(s1_data[8+k]), $signed(s1_data[12+k]),
                            s1_mode);
      assign col_next[k]    = cy[0];
      assign col_next[4+k]  = cy[1];
      assign col_next[8+k]  = cy[2];
      assign col_next[12+k] = cy[3];
   end

   // Per-block quantiser constants derived from the qp carried in S2.
   always_comb begin
      qdiv  = 4'(s2_qp / 6);
      qmod  = 3'(s2_qp % 6);
      qbits = 5'd15 + {1'b0, qdiv};
      fbase = (PW'(1) << qbits) / (s2_intra ? PW'(3) : PW'(6));
      rnd   = s2_mode ? (fbase << 1) : fbase;
      sh    = s2_mode ? (qbits + 5'd1) : qbits;
   end

   // Quantise every coefficient; DC blocks always use the class-a factor.
   for (genvar i = 0; i < 16; i++) begin : g_quant
      localparam pos_class_t POS_CLS =
         (((i / 4) % 2 == 0) && ((i % 4) % 2 == 0)) ? CLS_A :
         (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) ? CLS_B : CLS_C;
      pos_class_t cls;
      assign cls       = s2_mode ? CLS_A : POS_CLS;
      assign q_next[i] = quantise($signed(s2_data[i]), mf_lookup(qmod, cls), rnd, sh, s2_mode);
   end

   // Count the saturated coefficients that are non-zero.
   always_comb begin
      nzc_next = '0;
      for (int i = 0; i < 16; i++) begin
         if (q_next[i] != '0) begin
            nzc_next = nzc_next + 5'd1;
         end
      end
   end

   // S1: capture the row-pass result and block parameters on the handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_qp    <= '0;
         s1_mode  <= 1'b0;
         s1_intra <= 1'b0;
      end else if (advance) begin
         s1_valid <= bus.in_valid;
         if (accept) begin
            s1_data  <= row_next;
            s1_qp    <= qp_clamped;
            s1_mode  <= bus.mode;
            s1_intra <= bus.intra;
         end
      end
   end

   // S2: hold the full 2-D transform result with its block parameters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_qp    <= '0;
         s2_mode  <= 1'b0;
         s2_intra <= 1'b0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_data  <= col_next;
         s2_qp    <= s1_qp;
         s2_mode  <= s1_mode;
         s2_intra <= s1_intra;
      end
   end

   // S3: output register, frozen while the consumer withholds out_ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         nzc_q       <= '0;
      end else if (advance) begin
         out_valid_q <= s2_valid;
         out_data_q  <= q_next;
         nzc_q       <= nzc_next;
      end
   end

endmodule
